// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
//
// Scan controller that sits directly upstream of an 8:1 bit mux. It drives
// the mux select and reads back the selected bit. A start request makes it
// walk `sel` through all eight channels, holding each select for DIV clocks
// and sampling `mux_out` at the end of each step. The eight samples are then
// presented as one word on `data_out`, together with a one-cycle `done`
// strobe.
//
// Parameters:
//   DIV        clock cycles per select step (1..65535, 16-bit divide counter)
//   LSB_FIRST  1 = scan sel 0->7, 0 = scan sel 7->0. Bit n of data_out always
//              holds channel n, whichever direction the scan runs.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   start     in   scan request, only acted on while idle
//   abort     in   synchronous cancel of a scan in progress
//   sel       out  [2:0] registered mux select
//   mux_out   in   bit returned by the mux for the current sel
//   busy      out  high while a scan is in progress
//   done      out  one-cycle pulse when data_out is updated
//   data_out  out  [7:0] last completed word, held until the next completion
//   parity    out  XOR of the completed word (only with MUX_SCAN_PARITY_EN)
//
// Optional feature macro: MUX_SCAN_PARITY_EN adds the `parity` output.
// ---------------------------------------------------------------------------
module mux_scan_ctrl #(
    parameter int DIV       = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] sel,
    input  logic       mux_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    // Select value used while idle and as the first channel of every scan.
    localparam logic [2:0]  FIRST_SEL = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
    // Terminal count of the divide counter; a step ends when it is reached.
    localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [2:0]  step_cnt;
    logic [7:0]  capture;

    logic        tick;
    logic        last_step;
    logic [7:0]  capture_merged;
    logic [2:0]  sel_next;

    // The final sample is folded into the word combinationally so the
    // completion edge can publish all eight bits at once, without waiting
    // one more cycle for the capture register to catch up.
    always_comb begin
        tick                = (div_cnt == DIV_LAST);
        last_step           = (step_cnt == 3'd7);
        capture_merged      = capture;
        capture_merged[sel] = mux_out;
        sel_next            = (LSB_FIRST != 0) ? (sel + 3'd1) : (sel - 3'd1);
    end

    // Single state machine. done is a registered flag that defaults low on
    // every edge, so it can only ever be high for the cycle that follows a
    // completion. abort is checked before tick so that it wins even on the
    // eighth step, leaving data_out untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= FIRST_SEL;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= 8'h00;
            div_cnt  <= 16'd0;
            step_cnt <= 3'd0;
            capture  <= 8'h00;
`ifdef MUX_SCAN_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel      <= FIRST_SEL;
                    div_cnt  <= 16'd0;
                    step_cnt <= 3'd0;
                    capture  <= 8'h00;
                    if (start && !abort) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (abort) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        sel      <= FIRST_SEL;
                        div_cnt  <= 16'd0;
                        step_cnt <= 3'd0;
                    end else if (tick) begin
                        div_cnt <= 16'd0;
                        capture <= capture_merged;
                        if (last_step) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            data_out <= capture_merged;
                            sel      <= FIRST_SEL;
                            step_cnt <= 3'd0;
`ifdef MUX_SCAN_PARITY_EN
                            parity   <= ^capture_merged;
`endif
                        end else begin
                            step_cnt <= step_cnt + 3'd1;
                            sel      <= sel_next;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= FIRST_SEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
//
// Two controller instances share one clock: index 0 scans forwards with
// DIV=1, index 1 scans backwards with DIV=3. Each has its own mux model
// (mux_out = word[sel]). A behavioural model tracks every scan as "cycles
// elapsed since the start edge" and derives the expected select, busy, done
// and data from that, and a compare process checks every output of both
// instances on every falling edge. Directed sequences pin known values; a
// random phase then exercises start/abort/word changes freely.
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;

    localparam int DIV_A [2] = '{1, 3};
    localparam int LSB_A [2] = '{1, 0};

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_v = 2'b00;
    logic [1:0] abort_v = 2'b00;
    logic [7:0] in_v [2];
    logic [2:0] sel_v [2];
    logic [1:0] mux_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [7:0] data_v [2];
`ifdef MUX_SCAN_PARITY_EN
    logic [1:0] par_v;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state, one entry per instance.
    bit       m_busy [2];
    bit       m_done [2];
    int       m_elapsed [2];
    logic [7:0] m_word [2];
    logic [7:0] m_data [2];

    always #5 clk = ~clk;

    assign mux_v[0] = in_v[0][sel_v[0]];
    assign mux_v[1] = in_v[1][sel_v[1]];

    mux_scan_ctrl #(.DIV(1), .LSB_FIRST(1)) dut_fwd (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .sel(sel_v[0]), .mux_out(mux_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .data_out(data_v[0])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_v[0])
`endif
    );

    mux_scan_ctrl #(.DIV(3), .LSB_FIRST(0)) dut_rev (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .sel(sel_v[1]), .mux_out(mux_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .data_out(data_v[1])
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_v[1])
`endif
    );

    // Expected select: the channel index is simply elapsed cycles / DIV,
    // mapped onto the scan direction; idle parks on the first channel.
    function automatic logic [31:0] expSel(input int i);
        int c;
        if (!m_busy[i]) return (LSB_A[i] != 0) ? 32'd0 : 32'd7;
        c = m_elapsed[i] / DIV_A[i];
        return (LSB_A[i] != 0) ? 32'(c) : 32'(7 - c);
    endfunction

    // Reference model: a scan lasts 8*DIV edges; at the end of every DIV
    // cycles the channel currently selected is copied into the word.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_elapsed[i] = 0;
                m_word[i] = 8'h00;
                m_data[i] = 8'h00;
            end else begin
                m_done[i] = 1'b0;
                if (m_busy[i]) begin
                    if (abort_v[i]) begin
                        m_busy[i] = 1'b0;
                    end else begin
                        if ((m_elapsed[i] + 1) % DIV_A[i] == 0) begin
                            int c;
                            int idx;
                            c = m_elapsed[i] / DIV_A[i];
                            idx = (LSB_A[i] != 0) ? c : 7 - c;
                            m_word[i][idx] = in_v[i][idx];
                        end
                        m_elapsed[i] = m_elapsed[i] + 1;
                        if (m_elapsed[i] == 8 * DIV_A[i]) begin
                            m_data[i] = m_word[i];
                            m_done[i] = 1'b1;
                            m_busy[i] = 1'b0;
                        end
                    end
                end else if (start_v[i] && !abort_v[i]) begin
                    m_busy[i] = 1'b1;
                    m_elapsed[i] = 0;
                    m_word[i] = 8'h00;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("sel[%0d]", i), 32'(sel_v[i]), expSel(i));
                checkOutput($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_busy[i]));
                checkOutput($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
                checkOutput($sformatf("data[%0d]", i), 32'(data_v[i]), 32'(m_data[i]));
`ifdef MUX_SCAN_PARITY_EN
                checkOutput($sformatf("parity[%0d]", i), 32'(par_v[i]), 32'(^m_data[i]));
`endif
            end
        end
    end

    task automatic applyStimulus(input int i, input logic s, input logic a);
        start_v[i] = s;
        abort_v[i] = a;
    endtask

    // Start asserted across one rising edge; returns just after the falling
    // edge that follows that start edge.
    task automatic pulseStart(input int i);
        applyStimulus(i, 1'b1, 1'b0);
        @(negedge clk);
        #1 applyStimulus(i, 1'b0, 1'b0);
    endtask

    // Counts falling edges until done is seen, bounded by max_cyc.
    task automatic waitDone(input int i, input int max_cyc, output int n);
        n = 0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if (done_v[i]) break;
        end
    endtask

    initial begin
        int n;
        in_v[0] = 8'h00;
        in_v[1] = 8'h00;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("reset sel fwd", 32'(sel_v[0]), 32'd0);
        checkOutput("reset sel rev", 32'(sel_v[1]), 32'd7);
        checkOutput("reset busy", 32'(busy_v), 32'd0);
        checkOutput("reset data", 32'(data_v[0]), 32'h00);
        #1 rst = 1'b0;

        // Basic forward scan.
        in_v[0] = 8'hA5;
        pulseStart(0);
        checkOutput("fwd busy after start", 32'(busy_v[0]), 32'd1);
        waitDone(0, 40, n);
        checkOutput("fwd latency", 32'(n), 32'd8);
        checkOutput("fwd data A5", 32'(data_v[0]), 32'hA5);
`ifdef MUX_SCAN_PARITY_EN
        checkOutput("fwd parity A5", 32'(par_v[0]), 32'd0);
`endif

        // Reverse, slow scan.
        #1 in_v[1] = 8'h3C;
        pulseStart(1);
        waitDone(1, 60, n);
        checkOutput("rev latency", 32'(n), 32'd24);
        checkOutput("rev data 3C", 32'(data_v[1]), 32'h3C);

        // Complete with FF, then abort a scan of 00 at step 4.
        #1 in_v[0] = 8'hFF;
        pulseStart(0);
        waitDone(0, 40, n);
        checkOutput("data FF", 32'(data_v[0]), 32'hFF);
        #1 in_v[0] = 8'h00;
        pulseStart(0);
        repeat (3) @(negedge clk);
        #1 applyStimulus(0, 1'b0, 1'b1);
        @(negedge clk);
        #1 applyStimulus(0, 1'b0, 1'b0);
        checkOutput("abort busy", 32'(busy_v[0]), 32'd0);
        checkOutput("abort sel", 32'(sel_v[0]), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("abort keeps data", 32'(data_v[0]), 32'hFF);

        // Second start during a scan is ignored.
        #1 in_v[0] = 8'h96;
        pulseStart(0);
        repeat (2) @(negedge clk);
        #1;
        pulseStart(0);
        waitDone(0, 40, n);
        checkOutput("ignored start latency", 32'(n), 32'd5);
        checkOutput("data 96", 32'(data_v[0]), 32'h96);
        repeat (12) @(negedge clk);

        // Start held high: done every 9 cycles.
        #1 in_v[0] = 8'h5A;
        applyStimulus(0, 1'b1, 1'b0);
        waitDone(0, 40, n);
        waitDone(0, 40, n);
        checkOutput("held period 1", 32'(n), 32'd9);
        waitDone(0, 40, n);
        checkOutput("held period 2", 32'(n), 32'd9);
        checkOutput("held data 5A", 32'(data_v[0]), 32'h5A);
        #1 applyStimulus(0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a scan.
        #1 in_v[0] = 8'hC3;
        pulseStart(0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst busy", 32'(busy_v[0]), 32'd0);
        checkOutput("async rst sel", 32'(sel_v[0]), 32'd0);
        checkOutput("async rst data", 32'(data_v[0]), 32'h00);
        checkOutput("async rst done", 32'(done_v[0]), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        pulseStart(0);
        waitDone(0, 40, n);
        checkOutput("post rst latency", 32'(n), 32'd8);
        checkOutput("post rst data", 32'(data_v[0]), 32'hC3);

        // Parity words.
        #1 in_v[0] = 8'h07;
        pulseStart(0);
        waitDone(0, 40, n);
        checkOutput("data 07", 32'(data_v[0]), 32'h07);
`ifdef MUX_SCAN_PARITY_EN
        checkOutput("parity 07", 32'(par_v[0]), 32'd1);
`endif
        #1 in_v[0] = 8'h0F;
        pulseStart(0);
        waitDone(0, 40, n);
        checkOutput("data 0F", 32'(data_v[0]), 32'h0F);
`ifdef MUX_SCAN_PARITY_EN
        checkOutput("parity 0F", 32'(par_v[0]), 32'd0);
`endif

        // Random phase: the compare process does the checking.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                applyStimulus(i, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
                if ($urandom_range(0, 7) == 0) in_v[i] = 8'($urandom);
            end
        end
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
